// File: rtl/mtimer_rv32.sv
// mtimer_rv32: memory-mapped RISC-V machine timer (mtime / mtimecmp).
// Drives a registered timer_int level while mtime >= mtimecmp.
// Optional build macro MTIMER_PRESCALER_EN adds a 16-bit tick prescaler at
// word offset 0x10. Without it, mtime advances every cycle.
module mtimer_rv32 #(
  parameter logic [63:0] RST_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_int
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = 64;

  localparam logic [2:0] W_MTIME_LO = 3'd0;
  localparam logic [2:0] W_MTIME_HI = 3'd1;
  localparam logic [2:0] W_CMP_LO   = 3'd2;
  localparam logic [2:0] W_CMP_HI   = 3'd3;
  localparam logic [2:0] W_PRESCALE = 3'd4;

  logic [TW-1:0]   mtime;
  logic [TW-1:0]   mtimecmp;
  logic [XLEN-1:0] hi_shadow;
  logic [2:0]      word;
  logic            tick;
  logic            wr_mtime_lo;
  logic            wr_mtime_hi;
  logic            wr_cmp_lo;
  logic            wr_cmp_hi;
  logic            rd_mtime_lo;
  logic            unused_addr;

  // Byte-lane bits are don't-care; registers are word addressed.
  assign word        = addr[4:2];
  assign unused_addr = ^addr[1:0];

  assign wr_mtime_lo = wr_en && (word == W_MTIME_LO);
  assign wr_mtime_hi = wr_en && (word == W_MTIME_HI);
  assign wr_cmp_lo   = wr_en && (word == W_CMP_LO);
  assign wr_cmp_hi   = wr_en && (word == W_CMP_HI);
  assign rd_mtime_lo = rd_en && (word == W_MTIME_LO);

`ifdef MTIMER_PRESCALER_EN
  localparam int unsigned PW = 16;

  logic [PW-1:0] prescale;
  logic [PW-1:0] pcnt;
  logic          wr_prescale;

  assign wr_prescale = wr_en && (word == W_PRESCALE);
  assign tick        = (pcnt == prescale);

  // Prescale counter runs 0..prescale; a prescale store restarts it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescale <= '0;
      pcnt     <= '0;
    end else if (wr_prescale) begin
      prescale <= wdata[PW-1:0];
      pcnt     <= '0;
    end else if (tick) begin
      pcnt     <= '0;
    end else begin
      pcnt     <= pcnt + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  // mtime: a store to either half wins over the tick for the whole counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mtime <= '0;
    end else if (wr_mtime_lo) begin
      mtime[XLEN-1:0] <= wdata;
    end else if (wr_mtime_hi) begin
      mtime[TW-1:XLEN] <= wdata;
    end else if (tick) begin
      mtime <= mtime + TW'(1);
    end
  end

  // mtimecmp halves are independently writable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mtimecmp <= RST_CMP;
    end else if (wr_cmp_lo) begin
      mtimecmp[XLEN-1:0] <= wdata;
    end else if (wr_cmp_hi) begin
      mtimecmp[TW-1:XLEN] <= wdata;
    end
  end

  // Loading mtime lo snapshots the live upper half for a tear-free 64-bit read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hi_shadow <= '0;
    end else if (rd_mtime_lo) begin
      hi_shadow <= mtime[TW-1:XLEN];
    end
  end

  // Interrupt level compares registered values only, so no bus-to-irq path.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timer_int <= 1'b0;
    end else begin
      timer_int <= (mtime >= mtimecmp);
    end
  end

  // Zero-latency read mux; mtime hi always comes from the shadow.
  always_comb begin
    rdata = '0;
    case (word)
      W_MTIME_LO: rdata = mtime[XLEN-1:0];
      W_MTIME_HI: rdata = hi_shadow;
      W_CMP_LO:   rdata = mtimecmp[XLEN-1:0];
      W_CMP_HI:   rdata = mtimecmp[TW-1:XLEN];
`ifdef MTIMER_PRESCALER_EN
      W_PRESCALE: rdata = {16'd0, prescale};
`endif
      default:    rdata = '0;
    endcase
  end

endmodule

// File: doc/mtimer_rv32.md
# mtimer_rv32

Memory-mapped RISC-V machine timer that sits directly upstream of the CSR block's timer-interrupt input. Holds a 64-bit free-running `mtime` counter and a 64-bit `mtimecmp` compare value, and drives `timer_int` high while `mtime >= mtimecmp`. The CSR block gates `timer_int` with `mie[7]` and `mstatus[3]` and performs interrupt entry. Software reaches the timer through 32-bit loads and stores on the data bus.

## Interface
Parameters:
- `RST_CMP`, 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`, chosen so no interrupt fires out of reset.

Ports:
- `CLK`  input  1  sole clock; all state updates on the rising edge.
- `RST`  input  1  reset, synchronous, active-high.
- `addr`  input  5  byte offset within the timer window; `addr[1:0]` ignored.
- `wr_en`  input  1  store strobe, one cycle per store.
- `rd_en`  input  1  load strobe, one cycle per load.
- `wdata`  input  32  store data.
- `rdata`  output  32  load data, combinational from `addr`.
- `timer_int`  output  1  registered interrupt request to the CSR block.

## Operation
- Register map by word offset:
  - 0x00 `mtime[31:0]`
  - 0x04 `mtime[63:32]`
  - 0x08 `mtimecmp[31:0]`
  - 0x0C `mtimecmp[63:32]`
  - 0x10 `prescale[15:0]`, upper 16 bits read 0.
  - Other offsets read 0; writes to them are ignored.
- Reset values: `mtime` 0, `mtimecmp` `RST_CMP`, `prescale` 0, prescale counter 0, hi-shadow 0, `timer_int` 0.
- Counting: on each cycle where `tick`=1, `mtime` <= `mtime`+1, full 64-bit with carry from lo into hi. Wraps from all-ones to 0 with no flag.
- Writes:
  - A store to either `mtime` half replaces that half only.
  - On the cycle of any `mtime` store, increment is suppressed for both halves, so the write wins over the tick.
  - `mtimecmp` halves are written independently.
- Atomic 64-bit read:
  - A load (`rd_en`) of 0x00 returns live `mtime[31:0]` and, at the same edge, latches live `mtime[63:32]` into the hi-shadow.
  - A load of 0x04 returns the hi-shadow, not live `mtime[63:32]`.
  - `rdata` for 0x04 always shows the shadow, regardless of `rd_en`.
- Compare: `timer_int` <= (`mtime` >= `mtimecmp`), unsigned 64-bit, evaluated on register values every cycle. The level stays high until software raises `mtimecmp` or rewrites `mtime`.
- Simultaneous `wr_en` and `rd_en`: both take effect. A load of 0x00 returns the pre-write value.
- `RST` asserted mid-operation restores every reset value at the next edge, overriding any concurrent bus access.

## Timing
- `rdata` has zero latency: it is valid in the same cycle as `addr`.
- A store takes effect at the edge ending the `wr_en` cycle.
- `timer_int` latency:
  - It rises exactly 1 cycle after the edge at which `mtime` first reaches `mtimecmp`.
  - It falls 1 cycle after a `mtimecmp` store makes the compare false.
  - No combinational path from bus inputs to `timer_int`.
- A 64-bit carry completes in a single cycle: lo 0xFFFF_FFFF -> 0 and hi+1 at the same edge.

## Configuration
- `MTIMER_PRESCALER_EN` defined:
  - A 16-bit prescale counter runs 0..`prescale`. `tick`=1 on the cycle the counter equals `prescale`, and the counter then returns to 0.
  - `prescale`=0 gives a tick every cycle; `prescale`=N gives a tick every N+1 cycles.
  - A store to 0x10 loads `prescale` and clears the counter.
- `MTIMER_PRESCALER_EN` undefined:
  - `tick`=1 every cycle and no prescale logic is built.
  - 0x10 reads 0 and writes to it are ignored.

## Test plan
- Reset, then idle 10 cycles -> `mtime`=10 read via 0x00, `timer_int`=0, `rdata` for 0x08/0x0C = 0xFFFF_FFFF.
- Write `mtimecmp`={0,20} after reset -> `timer_int` first high in the cycle after `mtime` reaches 20, and stays high; then write `mtimecmp_lo`=1000 -> `timer_int` low 1 cycle later.
- Write `mtime`={0,0xFFFF_FFFE}, idle 2 cycles, load 0x00 then 0x04 -> 0x0000_0000 then 0x0000_0001. Write hi in between -> the 0x04 load still returns the shadow value 1.
- Same-cycle `mtime_lo` write of 5 while ticking -> `mtime_lo`=5 next cycle, then 6 after one more tick.
- (`MTIMER_PRESCALER_EN`) Write `prescale`=3 -> `mtime` increments once every 4 cycles. `RST` asserted mid-count -> all reset values next cycle, `prescale` read 0.
